id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning operand and data width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports id_valid (in, 1) and id_ready (out, 1), the decode-side handshake.
REQ-005 SHALL have port id_pc, input, XLEN, PC of the decoded instruction.
REQ-006 SHALL have ports id_rs1, id_rs2, id_rd, input, 5 each, register indices also driven to the register file.
REQ-007 SHALL have port id_imm, input, XLEN, sign-extended immediate.
REQ-008 SHALL have port id_ctrl, input, 8: alu_op[3:0], reg_write[4], mem_read[5], mem_write[6], alu_src[7].
REQ-009 SHALL have ports readdata1, readdata2, input, XLEN each, combinational register-file read data.
REQ-010 SHALL have ports exmem_rd (in, 5), exmem_reg_write (in, 1), exmem_result (in, XLEN), the EX/MEM forwarding source.
REQ-011 SHALL have ports memwb_rd (in, 5), memwb_reg_write (in, 1), memwb_writedata (in, XLEN), the MEM/WB forwarding source.
REQ-012 SHALL have port flush, input, 1, branch/jump squash.
REQ-013 SHALL have ports ex_valid (out, 1) and ex_ready (in, 1), the execute-side handshake.
REQ-014 SHALL have registered outputs ex_pc, ex_op1, ex_op2, ex_imm (XLEN each), ex_rd (5), ex_ctrl (8).

Function
REQ-015 SHALL capture all ID fields into the EX registers on the edge where id_valid && id_ready, latency exactly 1 cycle.
REQ-016 SHALL drive id_ready = (ex_ready || !ex_valid) && !load_use && !flush.
REQ-017 SHALL assert load_use when ex_valid && ex_ctrl[5] && ex_rd != 0 && ex_rd matches id_rs1 or id_rs2.
REQ-018 SHALL, when load_use and ex_ready, load a bubble (ex_valid=0) at the next edge; the ID instruction is accepted on the following edge.
REQ-019 SHALL hold every EX output unchanged while ex_valid && !ex_ready (and no flush).
REQ-020 SHALL clear ex_valid at the edge where flush=1, overriding capture and hold; other EX fields are don't-care.
REQ-021 SHALL clear ex_valid at the edge where ex_ready=1 and no ID transfer occurs.
REQ-022 SHALL select each operand with priority EX/MEM match, then MEM/WB match, then readdata; a match requires reg_write=1, rd != 0, rd == rs.
REQ-023 SHALL produce operand 0 whenever the source index is 0, regardless of forwarding or readdata.
REQ-024 SHALL apply forwarding at capture time only; held values are not re-forwarded.

Reset
REQ-025 SHALL, while reset=0, force ex_valid=0 and ex_pc, ex_op1, ex_op2, ex_imm, ex_rd, ex_ctrl to 0 immediately, independent of clk.
REQ-026 SHALL drive id_ready=0 while reset=0; the first capture occurs at the first edge after deassertion.
REQ-027 SHALL discard any instruction in flight when reset asserts mid-operation.

Configuration
REQ-028 SHALL compile forwarding (REQ-022, REQ-024) only when ID_EX_FWD_EN is defined.
REQ-029 SHALL, without ID_EX_FWD_EN, take operands from readdata1/readdata2 (zero for index 0) and treat a matching EX/MEM or MEM/WB write as a hazard stalling id_ready like REQ-017.

Structure
REQ-030 SHALL place XLEN, id_ctrl bit positions and ALU op encodings in shared package riscv_pkg.
REQ-031 SHALL implement operand selection as sub-module fwd_mux, instantiated once per operand.

Verification
REQ-032 Bench SHALL show: id_valid=1, id_rs1=5, readdata1=0x10, no matches -> next cycle ex_valid=1, ex_op1=0x10.
REQ-033 Bench SHALL show: exmem_rd=5, exmem_reg_write=1, exmem_result=0xAA, memwb_rd=5, memwb_writedata=0xBB, id_rs1=5 -> ex_op1=0xAA.
REQ-034 Bench SHALL show: EX holds load with ex_rd=7, id_rs2=7 -> id_ready=0 one cycle, bubble, then capture.
REQ-035 Bench SHALL show: ex_valid=1, ex_ready=0 for 3 cycles -> outputs stable; flush=1 -> ex_valid=0 next edge.
REQ-036 Bench SHALL show: id_rs1=0, exmem_rd=0, exmem_reg_write=1, exmem_result=0xFF -> ex_op1=0.
REQ-037 Bench SHALL show: reset=0 asserted between edges with ex_valid=1 -> ex_valid=0 and all outputs 0 without a clock edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the integer pipeline: datapath width, the layout of
// the 8-bit decode control word and the ALU operation encodings.
package riscv_pkg;

    localparam int XLEN = 64;

    // ALU operation encodings carried in ctrl_t.alu_op.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    // Control word bit positions: alu_src[7] mem_write[6] mem_read[5]
    // reg_write[4] alu_op[3:0].
    typedef struct packed {
        logic       alu_src;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
        logic [3:0] alu_op;
    } ctrl_t;

    // True when a pending register write targets source register rs.
    // x0 is never a real destination, so rd == 0 never matches.
    function automatic logic rd_match(input logic       reg_write,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs);
        return reg_write && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand selection for one source register of the ID/EX stage.
// Build option ID_EX_FWD_EN: when defined, results still in flight in EX/MEM
// and MEM/WB are forwarded ahead of the register file; otherwise the
// register-file value is used and the top stalls on those hazards instead.
module fwd_mux
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [4:0]      rs,
    input  logic [XLEN-1:0] readdata,
    input  logic [4:0]      exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [4:0]      memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_writedata,
    output logic [XLEN-1:0] operand
);

`ifdef ID_EX_FWD_EN
    // Youngest producer wins: EX/MEM over MEM/WB over the register file; x0 reads 0.
    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        operand = readdata;
        if (rd_match(memwb_reg_write, memwb_rd, rs)) operand = memwb_writedata;
        if (rd_match(exmem_reg_write, exmem_rd, rs)) operand = exmem_result;
        if (rs == 5'd0)                              operand = '0;
    end
`else
    // Register-file value only; x0 reads 0.
    always_comb begin
        operand = readdata;
        if (rs == 5'd0) operand = '0;
    end

    // Forwarding sources are not consumed in this build.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{exmem_rd, exmem_reg_write, exmem_result,
                            memwb_rd, memwb_reg_write, memwb_writedata};
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshakes, load-use stall,
// flush and operand selection at capture time.
// Build option ID_EX_FWD_EN: enables EX/MEM and MEM/WB operand forwarding;
// without it any pending write to a source register stalls decode.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_imm,
    input  logic [7:0]      id_ctrl,
    input  logic [XLEN-1:0] readdata1,
    input  logic [XLEN-1:0] readdata2,
    input  logic [4:0]      exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [4:0]      memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_writedata,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_op1,
    output logic [XLEN-1:0] ex_op2,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [7:0]      ex_ctrl
);

    logic            r_ex_valid;
    logic [XLEN-1:0] r_ex_pc;
    logic [XLEN-1:0] r_ex_op1;
    logic [XLEN-1:0] r_ex_op2;
    logic [XLEN-1:0] r_ex_imm;
    logic [4:0]      r_ex_rd;
    ctrl_t           r_ex_ctrl;

    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic            w_load_use;
    logic            w_hazard;
    logic            w_fire;

    fwd_mux #(.XLEN(XLEN)) u_fwd_op1 (
        .rs              (id_rs1),
        .readdata        (readdata1),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_writedata (memwb_writedata),
        .operand         (w_op1)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_op2 (
        .rs              (id_rs2),
        .readdata        (readdata2),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_writedata (memwb_writedata),
        .operand         (w_op2)
    );

    // A load sitting in EX cannot supply its data in time for a dependent instruction.
    assign w_load_use = r_ex_valid && r_ex_ctrl.mem_read &&
                        (rd_match(1'b1, r_ex_rd, id_rs1) ||
                         rd_match(1'b1, r_ex_rd, id_rs2));

`ifdef ID_EX_FWD_EN
    assign w_hazard = w_load_use;
`else
    // Without forwarding, wait until in-flight writes reach the register file.
    assign w_hazard = w_load_use ||
                      rd_match(exmem_reg_write, exmem_rd, id_rs1) ||
                      rd_match(exmem_reg_write, exmem_rd, id_rs2) ||
                      rd_match(memwb_reg_write, memwb_rd, id_rs1) ||
                      rd_match(memwb_reg_write, memwb_rd, id_rs2);
`endif

    // Accept from decode when EX is free or draining, with no hazard, squash or reset.
    assign id_ready = reset && (ex_ready || !r_ex_valid) && !w_hazard && !flush;
    assign w_fire   = id_valid && id_ready;

    // Valid bit: flush wins, then capture, then drain when EX consumes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_ex_valid <= 1'b0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_fire) begin
            r_ex_valid <= 1'b1;
        end else if (ex_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    // Payload: capture the decoded fields and selected operands on transfer, hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the payload is reset too because the outputs must read 0 while in reset.
            r_ex_pc   <= '0;
            r_ex_op1  <= '0;
            r_ex_op2  <= '0;
            r_ex_imm  <= '0;
            r_ex_rd   <= '0;
            r_ex_ctrl <= '0;
        end else if (w_fire) begin
            r_ex_pc   <= id_pc;
            r_ex_op1  <= w_op1;
            r_ex_op2  <= w_op2;
            r_ex_imm  <= id_imm;
            r_ex_rd   <= id_rd;
            r_ex_ctrl <= ctrl_t'(id_ctrl);
        end
    end

    assign ex_valid = r_ex_valid;
    assign ex_pc    = r_ex_pc;
    assign ex_op1   = r_ex_op1;
    assign ex_op2   = r_ex_op2;
    assign ex_imm   = r_ex_imm;
    assign ex_rd    = r_ex_rd;
    assign ex_ctrl  = r_ex_ctrl;

endmodule
